// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
//   Command sequencer and register bank sitting behind the SPI byte shifter.
//   The first byte of every frame is a command {rw, inc, addr[5:0]}; the
//   following bytes are either written into the register file (rw=0) or are
//   dummy bytes that trigger the next read byte to be handed to the shifter
//   (rw=1). Address 0 is a read-only ID, address 1 is a W1C STATUS register.
//   Everything runs in the sclk domain.
//
// Ports
//   sclk      in   SPI clock, all state changes on posedge
//   rst       in   asynchronous active-high reset
//   rx_valid  in   one-cycle strobe, rx_byte holds a received byte
//   rx_first  in   qualifies rx_valid: byte starts a new frame (command)
//   rx_byte   in   received byte
//   tx_byte   out  byte for the shifter to transmit next
//   tx_load   out  one-cycle strobe, shifter loads tx_byte
//   reg_flat  out  all registers, reg n at [8n+7:8n]
//   wr_pulse  out  one-cycle strobe, register wr_addr was just written
//   wr_addr   out  address of the last effective write
//   err       out  OR of STATUS[2:0]
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
    parameter int         NREGS     = 16,
    parameter logic [7:0] ID_VAL    = 8'hA5,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                 sclk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic                 rx_first,
    input  logic [7:0]           rx_byte,
    output logic [7:0]           tx_byte,
    output logic                 tx_load,
    output logic [8*NREGS-1:0]   reg_flat,
    output logic                 wr_pulse,
    output logic [5:0]           wr_addr,
    output logic                 err
);

    localparam int         IDX_W   = (NREGS > 2) ? $clog2(NREGS) : 1;
    localparam logic [6:0] NREGS_V = 7'(NREGS);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t      state;
    logic [5:0]  ptr;
    logic        inc;
    logic [2:0]  status;
    logic [7:0]  regs [NREGS];

    // Pointer advance. Anything at or past the last register (including an
    // out-of-range command address) wraps back to 0.
    function automatic logic [5:0] next_ptr(input logic [5:0] p);
        return ({1'b0, p} >= NREGS_V - 7'd1) ? 6'd0 : p + 6'd1;
    endfunction

    // Read address: command address on a read command, otherwise the
    // (possibly advanced) pointer for a read data byte.
    logic [5:0] rd_addr;
    logic       rd_bad;
    logic [7:0] rd_data;

    always_comb begin
        rd_addr = ptr;
        if (rx_first)
            rd_addr = rx_byte[5:0];
        else if (inc)
            rd_addr = next_ptr(ptr);
    end

    always_comb begin
        rd_bad  = ({1'b0, rd_addr} >= NREGS_V);
        rd_data = 8'hFF;
        if (rd_addr == 6'd0)
            rd_data = ID_VAL;
        else if (rd_addr == 6'd1)
            rd_data = {5'b0, status};
        else if (!rd_bad)
            rd_data = regs[rd_addr[IDX_W-1:0]];
    end

    // Per-byte decode: which action happens this cycle and which STATUS
    // bits get set or cleared. Only one byte arrives per cycle, so a set
    // and a W1C never target the same event; set still takes priority.
    logic       do_rd;
    logic       do_wr;
    logic       wr_bad;
    logic [2:0] st_set;
    logic [2:0] st_clr;

    always_comb begin
        do_rd  = 1'b0;
        do_wr  = 1'b0;
        st_set = 3'b000;
        st_clr = 3'b000;
        wr_bad = ({1'b0, ptr} >= NREGS_V);
        if (rx_valid) begin
            if (rx_first) begin
                do_rd = rx_byte[7];
            end else begin
                case (state)
                    IDLE: st_set[2] = 1'b1;
                    RD:   do_rd = 1'b1;
                    WR: begin
                        if (ptr == 6'd0)
                            st_set[1] = 1'b1;
                        else if (wr_bad)
                            st_set[0] = 1'b1;
                        else begin
                            do_wr = 1'b1;
                            if (ptr == 6'd1)
                                st_clr = rx_byte[2:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (do_rd && rd_bad)
            st_set[0] = 1'b1;
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 6'd0;
            inc      <= 1'b0;
            status   <= 3'b000;
            tx_byte  <= 8'h00;
            tx_load  <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= 6'd0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= RESET_VAL;
        end else begin
            tx_load  <= 1'b0;
            wr_pulse <= 1'b0;
            status   <= (status & ~st_clr) | st_set;

            if (rx_valid) begin
                if (rx_first) begin
                    ptr   <= rx_byte[5:0];
                    inc   <= rx_byte[6];
                    state <= rx_byte[7] ? RD : WR;
                end else if (state != IDLE && inc) begin
                    ptr <= next_ptr(ptr);
                end
            end

            if (do_rd) begin
                tx_byte <= rd_data;
                tx_load <= 1'b1;
            end

            if (do_wr) begin
                wr_pulse <= 1'b1;
                wr_addr  <= ptr;
                if (ptr >= 6'd2)
                    regs[ptr[IDX_W-1:0]] <= rx_byte;
            end
        end
    end

    // Register 0 and 1 are not storage: ID is a constant and STATUS has
    // only three live bits.
    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0)
                reg_flat[8*i +: 8] = ID_VAL;
            else if (i == 1)
                reg_flat[8*i +: 8] = {5'b0, status};
            else
                reg_flat[8*i +: 8] = regs[i];
        end
    end

    assign err = |status;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_ctrl
//   Directed scenarios followed by randomized frames, all compared against a
//   byte-level behavioural model of the register controller.
// ---------------------------------------------------------------------------
module tb_spi_reg_ctrl;

    localparam int         NREGS     = 16;
    localparam logic [7:0] ID_VAL    = 8'hA5;
    localparam logic [7:0] RESET_VAL = 8'h00;

    logic                sclk = 1'b0;
    logic                rst = 1'b0;
    logic                rx_valid = 1'b0;
    logic                rx_first = 1'b0;
    logic [7:0]          rx_byte = 8'h00;
    logic [7:0]          tx_byte;
    logic                tx_load;
    logic [8*NREGS-1:0]  reg_flat;
    logic                wr_pulse;
    logic [5:0]          wr_addr;
    logic                err;

    spi_reg_ctrl #(
        .NREGS     (NREGS),
        .ID_VAL    (ID_VAL),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .sclk     (sclk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .rx_byte  (rx_byte),
        .tx_byte  (tx_byte),
        .tx_load  (tx_load),
        .reg_flat (reg_flat),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .err      (err)
    );

    always #5 sclk = ~sclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Behavioural model: frame mode, pointer, register contents, STATUS.
    int          m_mode;      // 0 = no frame yet, 1 = write frame, 2 = read frame
    int          m_ptr;
    bit          m_inc;
    logic [7:0]  m_regs [NREGS];
    logic [7:0]  m_status;
    logic [7:0]  m_tx;
    logic [5:0]  m_waddr;
    bit          e_load;
    bit          e_wp;

    function automatic int nxt(input int p);
        return (p >= NREGS - 1) ? 0 : p + 1;
    endfunction

    function automatic logic [7:0] m_rd(input int a);
        logic [7:0] v;
        if (a == 0)          v = ID_VAL;
        else if (a == 1)     v = m_status;
        else if (a < NREGS)  v = m_regs[a];
        else begin
            v = 8'hFF;
            m_status[0] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [8*NREGS-1:0] m_flat();
        logic [8*NREGS-1:0] f;
        for (int i = 0; i < NREGS; i++) begin
            if (i == 0)      f[8*i +: 8] = ID_VAL;
            else if (i == 1) f[8*i +: 8] = m_status;
            else             f[8*i +: 8] = m_regs[i];
        end
        return f;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_ptr = 0; m_inc = 0;
        m_status = 8'h00; m_tx = 8'h00; m_waddr = 6'd0;
        e_load = 0; e_wp = 0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = RESET_VAL;
    endtask

    task automatic m_step(input bit first, input logic [7:0] b);
        e_load = 0;
        e_wp   = 0;
        if (first) begin
            m_inc  = b[6];
            m_ptr  = int'(b[5:0]);
            m_mode = b[7] ? 2 : 1;
            if (b[7]) begin
                m_tx   = m_rd(m_ptr);
                e_load = 1;
            end
        end else if (m_mode == 0) begin
            m_status[2] = 1'b1;
        end else if (m_mode == 2) begin
            if (m_inc) m_ptr = nxt(m_ptr);
            m_tx   = m_rd(m_ptr);
            e_load = 1;
        end else begin
            if (m_ptr == 0)
                m_status[1] = 1'b1;
            else if (m_ptr >= NREGS)
                m_status[0] = 1'b1;
            else begin
                e_wp    = 1;
                m_waddr = 6'(m_ptr);
                if (m_ptr == 1)
                    m_status = m_status & ~{5'b0, b[2:0]};
                else
                    m_regs[m_ptr] = b;
            end
            if (m_inc) m_ptr = nxt(m_ptr);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".tx_load"},  tx_load,  e_load);
        chk({where, ".tx_byte"},  tx_byte,  m_tx);
        chk({where, ".wr_pulse"}, wr_pulse, e_wp);
        chk({where, ".wr_addr"},  wr_addr,  m_waddr);
        chk({where, ".err"},      err,      |m_status[2:0]);
        chk({where, ".reg_flat"}, reg_flat, m_flat());
    endtask

    // One received byte, then an idle cycle in which both strobes must drop.
    task automatic send(input bit first, input logic [7:0] b);
        @(negedge sclk);
        rx_valid = 1'b1;
        rx_first = first;
        rx_byte  = b;
        m_step(first, b);
        @(posedge sclk);
        #1;
        check_all("byte");
        @(negedge sclk);
        rx_valid = 1'b0;
        rx_first = 1'b0;
        rx_byte  = 8'($urandom);
        e_load = 0;
        e_wp   = 0;
        @(posedge sclk);
        #1;
        chk("pulse_clr.tx_load",  tx_load,  1'b0);
        chk("pulse_clr.wr_pulse", wr_pulse, 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge sclk);
    endtask

    // Reset asserted between clock edges to exercise the asynchronous path.
    task automatic do_reset();
        @(negedge sclk);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_all("reset");
        @(negedge sclk);
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        do_reset();

        // Read ID
        send(1'b1, 8'h80);
        chk("id_read", tx_byte, 8'hA5);

        // Write with auto-increment at address 2
        send(1'b1, 8'h42);
        send(1'b0, 8'h11);
        chk("wr_addr_first", wr_addr, 6'd2);
        send(1'b0, 8'h22);
        chk("wr_addr_second", wr_addr, 6'd3);
        chk("reg2", reg_flat[23:16], 8'h11);
        chk("reg3", reg_flat[31:24], 8'h22);

        // Put known data in 14/15, then read across the wrap
        send(1'b1, 8'h4E);
        send(1'b0, 8'h3C);
        send(1'b0, 8'hC3);
        send(1'b1, 8'hCE);
        chk("wrap_r14", tx_byte, 8'h3C);
        send(1'b0, 8'h00);
        chk("wrap_r15", tx_byte, 8'hC3);
        send(1'b0, 8'h00);
        chk("wrap_r0", tx_byte, 8'hA5);
        send(1'b0, 8'h00);

        // Write to ID is dropped and flags STATUS[1]; W1C clears it
        send(1'b1, 8'h00);
        send(1'b0, 8'h55);
        chk("status_id_wr", reg_flat[15:8], 8'h02);
        chk("err_id_wr", err, 1'b1);
        send(1'b1, 8'h01);
        send(1'b0, 8'h02);
        chk("status_w1c", reg_flat[15:8], 8'h00);

        // Out-of-range read
        send(1'b1, 8'h90);
        chk("bad_rd_data", tx_byte, 8'hFF);
        chk("bad_rd_status", reg_flat[15:8], 8'h01);

        // Out-of-range read with inc continues from 0
        send(1'b1, 8'hD0);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);

        // Data byte straight after reset is a protocol error
        do_reset();
        send(1'b0, 8'h77);
        chk("idle_proto", reg_flat[15:8], 8'h04);

        // Reset mid write frame, following data byte ignored
        send(1'b1, 8'h45);
        send(1'b0, 8'h9A);
        do_reset();
        send(1'b0, 8'h5B);
        chk("post_rst_reg5", reg_flat[47:40], RESET_VAL);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            send($urandom_range(0, 3) == 0, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
